// File: rtl/char_draw_sched.sv
// Round-robin glyph draw scheduler: scans an 8x10 cell per request and emits plots.
// Optional CHAR_DRAW_BG_FILL_EN: plot every scan pixel, using BG_COLOUR off-glyph.
module char_draw_sched #(
    parameter int         CELL_W    = 8,
    parameter int         CELL_H    = 10,
    parameter logic [5:0] BG_COLOUR = 6'b000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [7:0] req0_x,
    input  logic [7:0] req0_y,
    input  logic [5:0] req0_code,
    input  logic [7:0] req1_x,
    input  logic [7:0] req1_y,
    input  logic [5:0] req1_code,
    output logic [1:0] grant,
    output logic       busy,
    output logic       done,
    output logic [5:0] glyph_code,
    output logic [7:0] glyph_x,
    output logic [7:0] glyph_y,
    output logic [7:0] scan_x,
    output logic [7:0] scan_y,
    input  logic       glyph_enable,
    input  logic [5:0] glyph_colour,
    output logic [7:0] plot_x,
    output logic [7:0] plot_y,
    output logic [5:0] plot_colour,
    output logic       plot
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [7:0] COL_LAST = 8'(CELL_W - 1);
    localparam logic [7:0] ROW_LAST = 8'(CELL_H - 1);

    state_t     state;
    logic [7:0] col;
    logic [7:0] row;
    logic       last_grant;
    logic       win;
    logic [5:0] pix_colour;

    assign busy   = (state != IDLE);
    assign scan_x = glyph_x + col;
    assign scan_y = glyph_y + row;

    // With both requesting, the one not served last wins.
    always_comb begin
        win = 1'b0;
        if (req == 2'b01)
            win = 1'b0;
        else if (req == 2'b10)
            win = 1'b1;
        else
            win = ~last_grant;
    end

    // Colour is only meaningful when a plot is issued.
    assign pix_colour = glyph_enable ? glyph_colour : BG_COLOUR;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            last_grant  <= 1'b1;
            grant       <= '0;
            done        <= 1'b0;
            plot        <= 1'b0;
            plot_x      <= '0;
            plot_y      <= '0;
            plot_colour <= '0;
            glyph_code  <= '0;
            glyph_x     <= '0;
            glyph_y     <= '0;
        end else begin
            grant <= '0;
            done  <= 1'b0;
            plot  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        glyph_code <= win ? req1_code : req0_code;
                        glyph_x    <= win ? req1_x : req0_x;
                        glyph_y    <= win ? req1_y : req0_y;
                        last_grant <= win;
                        grant      <= win ? 2'b10 : 2'b01;
                        col        <= '0;
                        row        <= '0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
`ifdef CHAR_DRAW_BG_FILL_EN
                    plot        <= 1'b1;
`else
                    plot        <= glyph_enable;
`endif
                    plot_x      <= scan_x;
                    plot_y      <= scan_y;
                    plot_colour <= pix_colour;
                    if (col == COL_LAST) begin
                        col <= '0;
                        if (row == ROW_LAST) begin
                            row   <= '0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            row <= row + 8'd1;
                        end
                    end else begin
                        col <= col + 8'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/char_draw_sched.md
Name: char_draw_sched

Overview:
- Sequencer and arbiter for the character-glyph datapath.
- Accepts draw requests from two requesters, each giving a glyph code and a screen origin, and grants them in round-robin order.
- For the granted request, scans every pixel of the 8x10 glyph cell and drives the scan coordinates into the shared glyph decoders, which are combinational.
- Converts the decoders' enable/colour response into plot writes for the VGA adapter.

Parameters:
- CELL_W, 8, glyph cell width in pixels (column offsets 0..CELL_W-1).
- CELL_H, 10, glyph cell height in pixels (row offsets 0..CELL_H-1).
- BG_COLOUR, 6'b000000, background colour; used only when BG_FILL_EN is defined.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  2  request per requester; held high until the matching grant bit is seen.
- req0_x, req0_y  in  8 each  requester 0 cell origin.
- req0_code  in  6  requester 0 glyph select.
- req1_x, req1_y, req1_code  in  8/8/6  same fields for requester 1.
- grant  out  2  one-hot, registered, one-cycle pulse on acceptance.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when a glyph finishes.
- glyph_code  out  6  latched code, drives the decoder mux select.
- glyph_x, glyph_y  out  8 each  latched origin, drives decoder x/y.
- scan_x, scan_y  out  8 each  absolute scan pixel, drives decoder flush_x/flush_y.
- glyph_enable  in  1  decoder hit for the current scan pixel, combinational.
- glyph_colour  in  6  decoder colour for the current scan pixel, combinational.
- plot_x, plot_y  out  8 each  pixel write coordinates.
- plot_colour  out  6  pixel write colour.
- plot  out  1  pixel write strobe.

Behaviour:
- Reset:
  - State is IDLE; col and row are 0; last_grant is 1, so requester 0 wins first.
  - grant, busy, done and plot are 0.
  - plot_x, plot_y, plot_colour, glyph_*, scan_x and scan_y are 0.
- Reset asserted mid-operation:
  - State goes to IDLE on the next edge.
  - plot and done are forced to 0; the aborted request is not completed; no done pulse is produced.
- States: IDLE, SCAN, DONE.
- IDLE:
  - If req is nonzero, select the winner: the single requester if only one, otherwise the one not equal to last_grant.
  - Latch the winner's code/x/y into glyph_*, update last_grant, set col=row=0, assert the grant bit for exactly one cycle (the first SCAN cycle), and go to SCAN.
  - If req is zero, stay in IDLE.
- SCAN, every cycle:
  - scan_x = glyph_x + col and scan_y = glyph_y + row, both 8-bit modulo 256 (wraps at the screen edge, no clipping).
  - Register plot <= glyph_enable, plot_x <= scan_x, plot_y <= scan_y, plot_colour <= glyph_colour. Plot output lags the scan by exactly one cycle.
  - Counter stepping:
    - col increments each cycle.
    - When col == CELL_W-1, col wraps to 0 and row increments.
    - When col == CELL_W-1 and row == CELL_H-1, go to DONE.
- DONE (one cycle):
  - The final pixel's plot appears in this cycle.
  - done = 1 and busy = 1.
  - Next state is IDLE, with plot returning to 0.
- Timing:
  - Scan length is CELL_W*CELL_H cycles (80 by default).
  - From grant pulse to done pulse is 80 cycles.
  - Back-to-back requests: a new grant is possible 2 cycles after done (one DONE cycle, then one IDLE acceptance cycle).
- Request handling:
  - req is sampled only in IDLE.
  - A req still high in IDLE after its own done is treated as a new request; requesters must drop req in the cycle after seeing grant.
  - Changes to req or req fields during SCAN are ignored, since the fields are latched.
- Simultaneous requests alternate strictly. No requester is granted twice in a row while the other is waiting.
- glyph_code/x/y hold stable from grant until the next acceptance.

Optional Feature:
- Macro: CHAR_DRAW_BG_FILL_EN.
- Defined: every scan pixel is plotted (plot = 1 for all 80 pixels). plot_colour is glyph_colour when glyph_enable = 1, otherwise BG_COLOUR. This clears the cell behind the glyph.
- Undefined: plot = glyph_enable; background pixels are not written; BG_COLOUR is unused.

Test Plan:
- Reset, then req=01 with code F, origin (10,20), decoder mux containing the 'F' glyph:
  - grant=01 pulses once.
  - Exactly 16 plot pulses, at (13..16,20), (13,21..25), (14..16,25), (13,26..29), colour 6'b111111.
  - done pulses 80 cycles after grant.
- req=11 held continuously:
  - grant order is 01, 10, 01, 10.
  - Each done is followed by a grant 2 cycles later.
- Origin (252,250), same glyph:
  - scan_x wraps 252..255,0..3 and scan_y wraps to 0..3.
  - Plots appear at (255,250..255), (0..2,250), (255,0..3), and so on; no hang.
- Assert reset at scan cycle 40:
  - Next cycle busy=0, plot=0, no done pulse.
  - A fresh req0 then completes normally with 16 plots.
- Change req0_x and req0_code during SCAN: plotted coordinates and glyph are unchanged from the latched values.
- With CHAR_DRAW_BG_FILL_EN defined and BG_COLOUR=6'b000011:
  - 80 plot pulses.
  - 16 pulses carry 6'b111111; the other 64 carry 6'b000011.
